// File: rtl/fft_128_reorder_if.sv
// Stream interface between the FFT controller output and the reorder stage.
// The master side drives din/din_valid; the slave side drives the reordered stream and status.
interface fft_128_reorder_if #(
   parameter int N_LOG2 = 7,
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic [N_LOG2-1:0] dout_index;
   logic              frame_done;
   logic              busy;
   logic              drop_err;

   modport master (
      output din,
      output din_valid,
      input  dout,
      input  dout_valid,
      input  dout_index,
      input  frame_done,
      input  busy,
      input  drop_err
   );

   modport slave (
      input  din,
      input  din_valid,
      output dout,
      output dout_valid,
      output dout_index,
      output frame_done,
      output busy,
      output drop_err
   );
endinterface

// File: rtl/fft_128_reorder.sv
// Captures one bit-reversed FFT frame and replays it in natural bin order.
// Optional build macro FFT_REORDER_SHIFT_EN selects fftshift output order (bins N/2..N-1 first).
module fft_128_reorder #(
   parameter int N_LOG2 = 7,
   parameter int DATA_W = 32
) (
   input logic              clk,
   input logic              rst,
   fft_128_reorder_if.slave bus
);

   localparam int N = 1 << N_LOG2;
   localparam logic [N_LOG2-1:0] CNT_LAST   = {N_LOG2{1'b1}};
   localparam logic [N_LOG2-1:0] CNT_ONE    = {{(N_LOG2-1){1'b0}}, 1'b1};
   localparam logic [N_LOG2-1:0] CNT_ZERO   = {N_LOG2{1'b0}};
   localparam logic [N_LOG2-1:0] SHIFT_MASK = {1'b1, {(N_LOG2-1){1'b0}}};
   localparam logic [DATA_W-1:0] DATA_ZERO  = {DATA_W{1'b0}};

   typedef enum logic [0:0] {
      ST_FILL  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
      logic [N_LOG2-1:0] r;
      for (int i = 0; i < N_LOG2; i++) begin
         r[i] = a[N_LOG2-1-i];
      end
      return r;
   endfunction

   logic [DATA_W-1:0] mem_r [N];

   state_t            state_r;
   state_t            state_s;
   logic [N_LOG2-1:0] wr_cnt_r;
   logic [N_LOG2-1:0] wr_cnt_s;
   logic [N_LOG2-1:0] rd_cnt_r;
   logic [N_LOG2-1:0] rd_cnt_s;
   logic [N_LOG2-1:0] wr_addr_s;
   logic [N_LOG2-1:0] rd_addr_s;
   logic              wr_en_s;
   logic              rd_en_s;
   logic              drop_s;
   logic              last_rd_s;

   logic [DATA_W-1:0] rd_data_r;
   logic              dout_valid_r;
   logic [N_LOG2-1:0] dout_index_r;
   logic              frame_done_r;
   logic              busy_r;
   logic              drop_err_r;

   // Next-state, counter and strobe decode for the fill/drain sequencer.
   always_comb begin
      state_s   = state_r;
      wr_cnt_s  = wr_cnt_r;
      rd_cnt_s  = rd_cnt_r;
      wr_en_s   = 1'b0;
      rd_en_s   = 1'b0;
      drop_s    = 1'b0;
      last_rd_s = 1'b0;
      wr_addr_s = bitrev(wr_cnt_r);
`ifdef FFT_REORDER_SHIFT_EN
      rd_addr_s = rd_cnt_r ^ SHIFT_MASK;
`else
      rd_addr_s = rd_cnt_r;
`endif
      case (state_r)
         ST_FILL: begin
            if (bus.din_valid) begin
               wr_en_s  = 1'b1;
               wr_cnt_s = wr_cnt_r + CNT_ONE;
               if (wr_cnt_r == CNT_LAST) begin
                  state_s = ST_DRAIN;
               end else begin
                  state_s = ST_FILL;
               end
            end else begin
               state_s = ST_FILL;
            end
         end
         ST_DRAIN: begin
            rd_en_s  = 1'b1;
            rd_cnt_s = rd_cnt_r + CNT_ONE;
            drop_s   = bus.din_valid;
            if (rd_cnt_r == CNT_LAST) begin
               last_rd_s = 1'b1;
               state_s   = ST_FILL;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         default: begin
            state_s  = ST_FILL;
            wr_cnt_s = CNT_ZERO;
            rd_cnt_s = CNT_ZERO;
         end
      endcase
   end

   // Sequencer state and frame counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ST_FILL;
         wr_cnt_r <= CNT_ZERO;
         rd_cnt_r <= CNT_ZERO;
      end else begin
         state_r  <= state_s;
         wr_cnt_r <= wr_cnt_s;
         rd_cnt_r <= rd_cnt_s;
      end
   end

   // Frame buffer write port; contents are deliberately left unreset so it maps to block RAM.
   always_ff @(posedge clk) begin
      if (wr_en_s && !rst) begin
         mem_r[wr_addr_s] <= bus.din;
      end
   end

   // Registered read port; the output register clears when idle so dout reads 0 outside bursts.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_r <= DATA_ZERO;
      end else if (rd_en_s) begin
         rd_data_r <= mem_r[rd_addr_s];
      end else begin
         rd_data_r <= DATA_ZERO;
      end
   end

   // Output qualifiers aligned with the read data, plus sticky overrun flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_valid_r <= 1'b0;
         dout_index_r <= CNT_ZERO;
         frame_done_r <= 1'b0;
         busy_r       <= 1'b0;
         drop_err_r   <= 1'b0;
      end else begin
         dout_valid_r <= rd_en_s;
         dout_index_r <= rd_en_s ? rd_addr_s : CNT_ZERO;
         frame_done_r <= last_rd_s;
         busy_r       <= (state_s == ST_DRAIN);
         drop_err_r   <= drop_err_r | drop_s;
      end
   end

   assign bus.dout       = rd_data_r;
   assign bus.dout_valid = dout_valid_r;
   assign bus.dout_index = dout_index_r;
   assign bus.frame_done = frame_done_r;
   assign bus.busy       = busy_r;
   assign bus.drop_err   = drop_err_r;

endmodule

// File: tb/tb_fft_128_reorder.sv
// Randomized bench for fft_128_reorder: a frame-level model predicts every output each cycle.
// Honours FFT_REORDER_SHIFT_EN so the same bench covers both output orders.
module tb_fft_128_reorder;

   localparam int N_LOG2 = 7;
   localparam int DATA_W = 32;
   localparam int N      = 128;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   fft_128_reorder_if #(.N_LOG2(N_LOG2), .DATA_W(DATA_W)) bus ();

   fft_128_reorder #(.N_LOG2(N_LOG2), .DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Model state: samples accepted so far, last completed frame and when it completed.
   logic [31:0] cap [$];
   logic [31:0] frame [N];
   int  cyc      = 0;
   int  t_last   = 0;
   bit  t_valid  = 1'b0;
   bit  drop_exp = 1'b0;
   bit  armed    = 1'b0;
   bit  pin_en   = 1'b0;

`ifdef FFT_REORDER_SHIFT_EN
   localparam bit SHIFT = 1'b1;
   int          pin_j [4] = '{0, 1, 64, 127};
   logic [31:0] pin_v [4] = '{32'd1, 32'd65, 32'd0, 32'd126};
`else
   localparam bit SHIFT = 1'b0;
   int          pin_j [4] = '{0, 1, 2, 127};
   logic [31:0] pin_v [4] = '{32'd0, 32'd64, 32'd32, 32'd127};
`endif

   function automatic int rev7(input int x);
      int r = 0;
      for (int b = 0; b < N_LOG2; b++) r = r * 2 + ((x >> b) & 1);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // Model: consume the inputs of the cycle ending at this edge.
   always @(posedge clk) begin
      bit draining;
      if (rst) begin
         cap.delete();
         t_valid  = 1'b0;
         drop_exp = 1'b0;
         armed    = 1'b1;
      end else begin
         draining = t_valid && (cyc >= t_last + 1) && (cyc <= t_last + N);
         if (bus.din_valid === 1'b1) begin
            if (draining) begin
               drop_exp = 1'b1;
            end else begin
               cap.push_back(bus.din);
               if (cap.size() == N) begin
                  for (int k = 0; k < N; k++) frame[k] = cap[k];
                  t_last  = cyc;
                  t_valid = 1'b1;
                  cap.delete();
               end
            end
         end
      end
      cyc++;
   end

   // Compare: every cycle after the first reset edge, check all outputs against the model.
   always @(negedge clk) begin
      bit          ev;
      bit          eb;
      int          j;
      int          idx;
      logic [31:0] ed;
      if (armed) begin
         ev  = t_valid && (cyc >= t_last + 2) && (cyc <= t_last + N + 1);
         eb  = t_valid && (cyc >= t_last + 1) && (cyc <= t_last + N);
         j   = cyc - t_last - 2;
         idx = SHIFT ? (j ^ 64) : j;
         ed  = ev ? frame[rev7(idx)] : 32'd0;
         check("dout",       bus.dout,                ed);
         check("dout_valid", 32'(bus.dout_valid),     32'(ev));
         check("dout_index", 32'(bus.dout_index),     ev ? 32'(idx) : 32'd0);
         check("frame_done", 32'(bus.frame_done),     32'(ev && (j == N - 1)));
         check("busy",       32'(bus.busy),           32'(eb));
         check("drop_err",   32'(bus.drop_err),       32'(drop_exp));
         if (pin_en && ev) begin
            for (int p = 0; p < 4; p++) begin
               if (j == pin_j[p]) check("pin_dout", bus.dout, pin_v[p]);
            end
         end
      end
   end

   task automatic drive(input bit v, input logic [31:0] d);
      bus.din_valid = v;
      bus.din       = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, $urandom);
   endtask

   // gap: 0 contiguous, 1 din_valid low every third cycle, 2 random gaps.
   task automatic send_frame(input bit rnd, input logic [31:0] base, input int gap);
      int sent = 0;
      int cc   = 0;
      while (sent < N) begin
         if ((gap == 1 && (cc % 3) == 2) || (gap == 2 && $urandom_range(0, 3) == 0)) begin
            drive(1'b0, $urandom);
         end else begin
            drive(1'b1, rnd ? $urandom : base + 32'(sent));
            sent++;
         end
         cc++;
      end
   endtask

   initial begin
      bus.din_valid = 1'b0;
      bus.din       = 32'd0;
      rst           = 1'b1;
      @(posedge clk);
      #1;
      // Reset hold with toggling input.
      for (int i = 0; i < 3; i++) drive(1'(i % 2 == 0), $urandom);
      rst = 1'b0;

      // Single contiguous frame, din = k.
      pin_en = 1'b1;
      send_frame(1'b0, 32'd0, 0);
      idle(N + 2);
      pin_en = 1'b0;

      // Gapped input, same data.
      send_frame(1'b0, 32'd0, 1);
      idle(N + 2);

      // Back-to-back frames, second starts the first cycle FILL resumes.
      send_frame(1'b1, 32'd0, 0);
      idle(N);
      send_frame(1'b0, 32'h1000, 0);
      idle(N + 2);

      // Overrun during drain, then a full frame.
      send_frame(1'b1, 32'd0, 2);
      idle(10);
      repeat (5) drive(1'b1, $urandom);
      idle(N - 15);
      send_frame(1'b1, 32'd0, 0);
      idle(N + 2);

      // Reset while output j=40 is on the bus, then a din = k frame.
      send_frame(1'b1, 32'd0, 0);
      idle(41);
      rst = 1'b1;
      drive(1'b1, $urandom);
      rst = 1'b0;
      send_frame(1'b0, 32'd0, 0);
      idle(N + 2);

      // Partial frame discarded by reset mid-fill.
      for (int i = 0; i < 50; i++) drive(1'b1, $urandom);
      rst = 1'b1;
      drive(1'b0, 32'd0);
      rst = 1'b0;

      // Random frames with random gaps and random spacing (may overrun).
      for (int f = 0; f < 4; f++) begin
         send_frame(1'b1, 32'd0, 2);
         idle($urandom_range(N - 20, N + 5));
      end
      idle(N + 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
